// File: rtl/compress_latch_ctrl.sv
// Ping-pong sequencer for the two 128-bit latch banks in front of the
// compressor. Tracks which bank is free/full, raises a one-hot latch enable
// on each accepted word, steers the read mux, and tags block boundaries.
module compress_latch_ctrl #(
   parameter int BLOCK_WORDS = 4,
   parameter int CNT_W       = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1,
   parameter int BLK_CNT_W   = 16
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic                 i_flush,
   input  logic                 i_in_valid,
   output logic                 o_in_ready,
   output logic [1:0]           o_latch_en,
   output logic                 o_rd_sel,
   output logic                 o_out_valid,
   input  logic                 i_out_ready,
   output logic                 o_out_first,
   output logic                 o_out_last,
   output logic [CNT_W-1:0]     o_word_idx,
   output logic [BLK_CNT_W-1:0] o_blocks_done,
   output logic                 o_busy
);

   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BLOCK_WORDS - 1);

   logic [1:0]           full;
   logic [1:0]           full_nxt;
   logic                 wr_ptr;
   logic                 rd_ptr;
   logic [CNT_W-1:0]     word_idx;
   logic [BLK_CNT_W-1:0] blocks_done;
   logic                 accept;
   logic                 drain;

   // A flush cycle blocks both handshakes so nothing is captured or consumed
   assign o_in_ready  = ~full[wr_ptr] & ~i_flush;
   assign accept      = i_in_valid & o_in_ready;
   assign o_out_valid = full[rd_ptr] & ~i_flush;
   assign drain       = o_out_valid & i_out_ready;

   // Enables are suppressed while reset is held so no bank opens during reset
   assign o_latch_en[0] = accept & i_reset & ~wr_ptr;
   assign o_latch_en[1] = accept & i_reset & wr_ptr;

   assign o_rd_sel      = rd_ptr;
   assign o_out_first   = (word_idx == '0);
   assign o_out_last    = (word_idx == LAST_IDX);
   assign o_word_idx    = word_idx;
   assign o_blocks_done = blocks_done;
   assign o_busy        = |full;

   // Next occupancy: accept and drain always hit different banks
   always_comb begin
      full_nxt = full;
      if (accept) full_nxt[wr_ptr] = 1'b1;
      if (drain)  full_nxt[rd_ptr] = 1'b0;
   end

   // Bank pointers, block position and block counter
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         full        <= '0;
         wr_ptr      <= 1'b0;
         rd_ptr      <= 1'b0;
         word_idx    <= '0;
         blocks_done <= '0;
      end else if (i_flush) begin
         full     <= '0;
         wr_ptr   <= 1'b0;
         rd_ptr   <= 1'b0;
         word_idx <= '0;
      end else begin
         full <= full_nxt;
         if (accept) wr_ptr <= ~wr_ptr;
         if (drain) begin
            rd_ptr <= ~rd_ptr;
            if (o_out_last) begin
               word_idx    <= '0;
               blocks_done <= blocks_done + 1'b1;
            end else begin
               word_idx <= word_idx + 1'b1;
            end
         end
      end
   end

   // A bank can never be written and read out in the same cycle
   always_ff @(posedge i_clk) begin
      if (i_reset && accept && drain) assert (wr_ptr != rd_ptr);
   end

endmodule

// File: tb/tb_compress_latch_ctrl.sv
// Directed bench for compress_latch_ctrl: reset, streaming, backpressure,
// flush, mid-run reset, counter wrap, and single-word blocks.
module tb_compress_latch_ctrl;

   logic       i_clk = 1'b0;
   logic       i_reset;
   logic       i_flush;
   logic       i_in_valid;
   logic       i_out_ready;

   logic       in_ready0, rd_sel0, out_valid0, out_first0, out_last0, busy0;
   logic [1:0] latch_en0;
   logic [1:0] word_idx0;
   logic [3:0] blocks0;

   logic        in_ready1, rd_sel1, out_valid1, out_first1, out_last1, busy1;
   logic [1:0]  latch_en1;
   logic [0:0]  word_idx1;
   logic [15:0] blocks1;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   compress_latch_ctrl #(.BLOCK_WORDS(4), .BLK_CNT_W(4)) dut0 (
      .i_clk(i_clk), .i_reset(i_reset), .i_flush(i_flush),
      .i_in_valid(i_in_valid), .o_in_ready(in_ready0), .o_latch_en(latch_en0),
      .o_rd_sel(rd_sel0), .o_out_valid(out_valid0), .i_out_ready(i_out_ready),
      .o_out_first(out_first0), .o_out_last(out_last0), .o_word_idx(word_idx0),
      .o_blocks_done(blocks0), .o_busy(busy0)
   );

   compress_latch_ctrl #(.BLOCK_WORDS(1), .BLK_CNT_W(16)) dut1 (
      .i_clk(i_clk), .i_reset(i_reset), .i_flush(i_flush),
      .i_in_valid(i_in_valid), .o_in_ready(in_ready1), .o_latch_en(latch_en1),
      .o_rd_sel(rd_sel1), .o_out_valid(out_valid1), .i_out_ready(i_out_ready),
      .o_out_first(out_first1), .o_out_last(out_last1), .o_word_idx(word_idx1),
      .o_blocks_done(blocks1), .o_busy(busy1)
   );

   // Free-running 10 ns clock
   always #5 i_clk = ~i_clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic applyStimulus(input logic rst, input logic inv, input logic outr, input logic flush);
      i_reset     = rst;
      i_in_valid  = inv;
      i_out_ready = outr;
      i_flush     = flush;
      #1;
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, " latch_en"},  latch_en0, 2'b00);
      checkOutput({tag, " in_ready"},  in_ready0, 1'b1);
      checkOutput({tag, " out_valid"}, out_valid0, 1'b0);
      checkOutput({tag, " rd_sel"},    rd_sel0, 1'b0);
      checkOutput({tag, " first"},     out_first0, 1'b1);
      checkOutput({tag, " last"},      out_last0, 1'b0);
      checkOutput({tag, " word_idx"},  word_idx0, 2'd0);
      checkOutput({tag, " blocks"},    blocks0, 4'd0);
      checkOutput({tag, " busy"},      busy0, 1'b0);
   endtask

   // Linear directed sequence
   initial begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);

      // Reset held with a word offered: nothing may latch
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput("rst latch_en", latch_en0, 2'b00);
         checkOutput("rst in_ready", in_ready0, 1'b1);
         checkOutput("rst out_valid", out_valid0, 1'b0);
         checkOutput("rst blocks", blocks0, 4'd0);
      end
      tick();
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      checkResetValues("release");
      checkOutput("release dut1 last", out_last1, 1'b1);

      // Streaming 8 words with both sides always ready
      for (int k = 0; k <= 8; k++) begin
         tick();
         applyStimulus(1'b1, k < 8, 1'b1, 1'b0);
         checkOutput("stream in_ready", in_ready0, 1'b1);
         checkOutput("stream latch_en", latch_en0,
                     (k == 8) ? 2'b00 : ((k % 2 == 0) ? 2'b01 : 2'b10));
         checkOutput("stream out_valid", out_valid0, k >= 1);
         if (k >= 1) begin
            checkOutput("stream rd_sel", rd_sel0, (k - 1) % 2);
            checkOutput("stream word_idx", word_idx0, (k - 1) % 4);
            checkOutput("stream first", out_first0, ((k - 1) % 4) == 0);
            checkOutput("stream last", out_last0, ((k - 1) % 4) == 3);
            checkOutput("bw1 first", out_first1, 1'b1);
            checkOutput("bw1 last", out_last1, 1'b1);
         end
      end
      tick();
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("stream blocks", blocks0, 4'd2);
      checkOutput("stream busy", busy0, 1'b0);
      checkOutput("stream out_valid end", out_valid0, 1'b0);
      checkOutput("bw1 blocks", blocks1, 16'd8);

      // Backpressure: compressor stalled, three words offered
      tick();
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      checkOutput("bp0 latch_en", latch_en0, 2'b01);
      tick();
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      checkOutput("bp1 latch_en", latch_en0, 2'b10);
      checkOutput("bp1 out_valid", out_valid0, 1'b1);
      tick();
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      checkOutput("bp2 in_ready", in_ready0, 1'b0);
      checkOutput("bp2 latch_en", latch_en0, 2'b00);
      checkOutput("bp2 busy", busy0, 1'b1);
      tick();
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
      checkOutput("bp3 in_ready", in_ready0, 1'b0);
      checkOutput("bp3 rd_sel", rd_sel0, 1'b0);
      checkOutput("bp3 word_idx", word_idx0, 2'd0);
      tick();
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      checkOutput("bp4 in_ready", in_ready0, 1'b1);
      checkOutput("bp4 latch_en", latch_en0, 2'b01);
      checkOutput("bp4 rd_sel", rd_sel0, 1'b1);
      checkOutput("bp4 word_idx", word_idx0, 2'd1);
      tick();
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
      checkOutput("bp5 in_ready", in_ready0, 1'b0);
      checkOutput("bp5 out_valid", out_valid0, 1'b1);

      // Flush with two words drained and one buffered
      tick();
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
      checkOutput("flush word_idx pre", word_idx0, 2'd2);
      checkOutput("flush in_ready", in_ready0, 1'b0);
      checkOutput("flush out_valid", out_valid0, 1'b0);
      checkOutput("flush latch_en", latch_en0, 2'b00);
      tick();
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("postflush out_valid", out_valid0, 1'b0);
      checkOutput("postflush word_idx", word_idx0, 2'd0);
      checkOutput("postflush rd_sel", rd_sel0, 1'b0);
      checkOutput("postflush busy", busy0, 1'b0);
      checkOutput("postflush blocks", blocks0, 4'd2);
      tick();
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      checkOutput("postflush latch_en", latch_en0, 2'b01);
      tick();
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("postflush valid", out_valid0, 1'b1);
      checkOutput("postflush first", out_first0, 1'b1);

      // Stream 14 words to reach blocks_done=5, word_idx=2
      for (int n = 0; n < 14; n++) begin
         tick();
         applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
         checkOutput("run out_valid", out_valid0, 1'b1);
         checkOutput("run word_idx", word_idx0, n % 4);
      end
      tick();
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      checkOutput("full in_ready", in_ready0, 1'b0);
      checkOutput("full busy", busy0, 1'b1);
      checkOutput("full word_idx", word_idx0, 2'd2);
      checkOutput("full blocks", blocks0, 4'd5);

      // Reset mid-operation for one cycle
      tick();
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      checkResetValues("midrst");

      // 17 blocks through a 4-bit counter wraps to 1
      for (int k = 0; k <= 68; k++) begin
         tick();
         applyStimulus(1'b1, k < 68, 1'b1, 1'b0);
         if (k == 65) checkOutput("wrap blocks at 16", blocks0, 4'd0);
      end
      tick();
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("wrap blocks", blocks0, 4'd1);
      checkOutput("wrap busy", busy0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
